shared_unit_arbiter: RTL
========================

# shared_unit_arbiter

Round-robin controller that shares one `wd`-bit pipelined processing unit, such as an `or_gate` instance, among `nreq` requesters. It arbitrates among the requesters, forwards the granted operand to the unit and waits the unit's fixed latency. It then captures the result and returns it to the winning requester with a one-cycle acknowledge. It sits between requester-side logic and the single shared unit instance in the enclosing module.

## Interface
- `wd`, 4: operand and result width in bits.
- `nreq`, 4: number of requesters, 2..16.
- `lat`, 2: unit latency in cycles from `unit_vld` to a valid `unit_out`, ≥1.
- `idw`, derived: max(1, ceil(log2(nreq))).

- `clk`  input  1  single clock; all state changes on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  nreq  request per requester; bit i = requester i.
- `din`  input  nreq*wd  flattened operands; requester i uses bits [i*wd +: wd].
- `ack`  output  nreq  one-hot, one-cycle completion pulse.
- `dout`  output  wd  result of the most recent completed transaction.
- `grant_id`  output  idw  index of the current or last granted requester.
- `busy`  output  1  high while a transaction is in flight.
- `unit_in`  output  wd  operand driven to the shared unit.
- `unit_vld`  output  1  one-cycle issue strobe to the unit.
- `unit_out`  input  wd  unit result, valid `lat` cycles after `unit_vld`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - If `req` is non-zero, grant the first set bit found searching from round-robin pointer `ptr` upward, wrapping at nreq-1 to 0.
  - Latch the winner's index into `grant_id` and its `din` slice into `unit_in`. Go to ISSUE.
  - If `req` is zero, stay in IDLE.
- ISSUE:
  - `unit_vld`=1 for exactly this cycle.
  - Load the wait counter with lat-1. Go to WAIT.
- WAIT:
  - Lasts exactly `lat` cycles; the counter decrements each cycle.
  - At the edge ending the cycle where the counter reads 0, capture `unit_out` into `dout`. Go to DONE.
- DONE:
  - `ack[grant_id]`=1 for this cycle only.
  - Set `ptr` to grant_id+1, wrapping to 0 after nreq-1. Go to IDLE.
- `busy`=1 in ISSUE, WAIT and DONE; 0 in IDLE.
- Requests are sampled only in IDLE. `req` changes during ISSUE, WAIT or DONE are ignored.
- The operand is latched at grant, so `din` may change after the grant edge.
- If a requester drops `req` after its grant, its transaction still completes and is still acked.
- A requester holding `req` high after its `ack` is treated as a new request and re-arbitrated from IDLE. The pointer has already advanced past it, so it is served after the other pending requesters.
- At most one transaction is in flight; the unit never sees overlapping strobes.
- `dout` and `grant_id` hold their values until the next capture or grant.
- Reset values: state IDLE, `ptr`=0, `ack`=0, `unit_vld`=0, `unit_in`=0, `dout`=0, `grant_id`=0, `busy`=0.
- Reset asserted mid-transaction aborts it with no `ack`. After release, arbitration restarts from `ptr`=0.

## Timing
- Edge 0 samples `req` in IDLE.
- Cycle 1 is ISSUE, with `unit_vld` high.
- Cycles 2..lat+1 are WAIT; `unit_out` is captured at the end of cycle lat+1.
- Cycle lat+2 is DONE: `ack` and the new `dout` are visible.
- Cycle lat+3 is IDLE, and a new grant edge follows.
- Request-to-ack latency is lat+2 cycles. Back-to-back throughput is one transaction per lat+3 cycles.
- All outputs are registered; there is no combinational path from `req` or `din` to any output.

## Test plan
- Bench unit model: `unit_out` = `unit_in` ^ 4'hF, delayed `lat` cycles. Defaults wd=4, nreq=4, lat=2 unless stated.
- Single request: `req`=4'b0001, din0=4'hA at edge 0 -> `unit_vld` in cycle 1, `ack`=4'b0001 and `dout`=4'h5 in cycle 4, `busy` low in cycle 5.
- All requesters held at `req`=4'b1111 with distinct operands -> grants in order 0,1,2,3,0; `ack` pulses 5 cycles apart with correct `dout` for each.
- Pointer wrap: serve requester 3, then `req`=4'b1001 -> requester 0 is granted next, not 3.
- Requester 2 drops `req` in its ISSUE cycle and changes `din` -> `ack`=4'b0100 still pulses with the result of the originally latched operand.
- Reset mid-WAIT: assert `rst_n`=0 during cycle 2 -> all outputs at reset values immediately and no `ack`. After release with `req`=4'b0010, requester 1 is served with `grant_id`=1.
- lat=1 build: single request -> `ack` in cycle 3 with correct `dout`.

Source files
------------

// File: rtl/shared_unit_arbiter_if.sv
// shared_unit_arbiter_if: requester and shared-unit signals; master = requester/unit side, slave = arbiter
interface shared_unit_arbiter_if #(
  parameter int wd   = 4,
  parameter int nreq = 4,
  parameter int idw  = (nreq > 2) ? $clog2(nreq) : 1
);
  logic [nreq-1:0]    req;
  logic [nreq*wd-1:0] din;
  logic [nreq-1:0]    ack;
  logic [wd-1:0]      dout;
  logic [idw-1:0]     grant_id;
  logic               busy;
  logic [wd-1:0]      unit_in;
  logic               unit_vld;
  logic [wd-1:0]      unit_out;
  modport master (output req, din, unit_out, input ack, dout, grant_id, busy, unit_in, unit_vld);
  modport slave  (input req, din, unit_out, output ack, dout, grant_id, busy, unit_in, unit_vld);
endinterface

// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: round-robin sharing of one lat-cycle pipelined unit among nreq requesters
// ports: clk, rst_n (async active-low); bus.slave carries req/din/ack/dout/grant_id/busy and unit_in/unit_vld/unit_out
module shared_unit_arbiter #(
  parameter int wd   = 4,
  parameter int nreq = 4,
  parameter int lat  = 2
) (
  input logic clk,
  input logic rst_n,
  shared_unit_arbiter_if.slave bus
);
  localparam int idw = (nreq > 2) ? $clog2(nreq) : 1;
  localparam int cw  = (lat > 1) ? $clog2(lat) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t          state_q, state_d;
  logic [idw-1:0]  ptr_q, ptr_d, grant_q, grant_d, win;
  logic [cw-1:0]   cnt_q, cnt_d;
  logic [wd-1:0]   unit_in_q, unit_in_d, dout_q, dout_d;
  logic [nreq-1:0] ack_q, ack_d;
  logic            vld_q, vld_d, busy_q, busy_d;
  // scan downward so the closest set bit at or above ptr wins last
  always_comb begin
    win = ptr_q;
    for (int k = nreq - 1; k >= 0; k--)
      if (bus.req[(int'(ptr_q) + k) % nreq]) win = idw'((int'(ptr_q) + k) % nreq);
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    unit_in_d = unit_in_q;
    dout_d    = dout_q;
    ack_d     = '0;
    vld_d     = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: if (|bus.req) begin
        grant_d   = win;
        unit_in_d = bus.din[win*wd +: wd];
        vld_d     = 1'b1;
        busy_d    = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: begin
        cnt_d   = cw'(lat - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        dout_d  = bus.unit_out;
        ack_d   = {{(nreq-1){1'b0}}, 1'b1} << grant_q;
        state_d = DONE;
      end else cnt_d = cnt_q - 1'b1;
      DONE: begin
        ptr_d   = (grant_q == idw'(nreq - 1)) ? '0 : grant_q + 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      unit_in_q <= '0;
      dout_q    <= '0;
      ack_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      unit_in_q <= unit_in_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
    end
  assign bus.ack      = ack_q;
  assign bus.dout     = dout_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.unit_in  = unit_in_q;
  assign bus.unit_vld = vld_q;
endmodule
